// File: rtl/adi_dma_comb_ctrl.sv
// Job sequencer for the DMA combiner: queues jobs, drives cmd/num_pkts, watches status[0].
// Optional watchdog is built only when ADI_DMA_COMB_CTRL_TIMEOUT_EN is defined.
module adi_dma_comb_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_W  = 24
) (
    input  logic                 AXIS_ACLK,
    input  logic                 AXIS_ARESETN,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [31:0]          job_num_pkts,
    input  logic                 job_passthrough,
    input  logic                 abort,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic [31:0]          cmd,
    output logic [31:0]          num_pkts,
    input  logic [31:0]          status,
    output logic                 busy,
    output logic                 done_irq,
    output logic                 err_irq,
    output logic [1:0]           last_err,
    output logic [15:0]          jobs_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ZERO    = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FINISH, S_ABORT} state_t;

    // Handshake: a job is accepted on a cycle where job_valid and job_ready are both 1
    // and abort is 0; job_ready depends only on queue fullness.
    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, empty;
    logic [32:0]   head;

    assign empty     = (count_q == '0);
    assign job_ready = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push      = job_valid & job_ready & ~abort;
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge AXIS_ACLK) begin
        if (push) mem_q[wr_ptr_q] <= {job_passthrough, job_num_pkts};
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    state_t      state_q, state_d;
    logic        clr_q, clr_d;
    logic        pt_q, pt_d;
    logic [31:0] num_q, num_d;
    logic [2:0]  cmd_q, cmd_d;
    logic        done_q, done_d, err_q, err_d;
    logic [1:0]  last_err_q, last_err_d;
    logic [15:0] jobs_q, jobs_d;
    logic        timeout_hit;

`ifdef ADI_DMA_COMB_CTRL_TIMEOUT_EN
    // Counter reads 0 in the first RUN cycle and fires when it equals the limit.
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    always_comb wd_d = (state_q == S_RUN) ? wd_q + TIMEOUT_W'(1) : '0;
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) wd_q <= '0;
        else               wd_q <= wd_d;
    end
    assign timeout_hit = (timeout_cycles != '0) && (wd_q == timeout_cycles);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    logic unused_status;
    assign unused_status = ^status[31:1];

    always_comb begin
        state_d    = state_q;
        clr_d      = clr_q;
        pt_d       = pt_q;
        num_d      = num_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        last_err_d = last_err_q;
        jobs_d     = jobs_q;
        pop        = 1'b0;
        if (abort) begin
            if (state_q != S_IDLE) begin
                state_d    = S_ABORT;
                clr_d      = 1'b0;
                err_d      = 1'b1;
                last_err_d = ERR_ABORT;
            end else if (!empty) begin
                err_d      = 1'b1;
                last_err_d = ERR_ABORT;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        pop   = 1'b1;
                        num_d = head[31:0];
                        pt_d  = head[32];
                        if (head[31:0] == '0 && !head[32]) begin
                            err_d      = 1'b1;
                            last_err_d = ERR_ZERO;
                        end else begin
                            state_d = S_CLEAR;
                            clr_d   = 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    clr_d = 1'b1;
                    if (clr_q) state_d = S_RUN;
                end
                S_RUN: begin
                    if (pt_q ? !empty : status[0]) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        jobs_d  = jobs_q + 16'd1;
                    end else if (!pt_q && timeout_hit) begin
                        state_d    = S_ABORT;
                        clr_d      = 1'b0;
                        err_d      = 1'b1;
                        last_err_d = ERR_TIMEOUT;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                S_ABORT: begin
                    clr_d = 1'b1;
                    if (clr_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so cmd lines up with the state it names.
    always_comb begin
        cmd_d = 3'b000;
        case (state_d)
            S_CLEAR, S_ABORT: cmd_d = 3'b010;
            S_RUN:            cmd_d = {pt_d, 1'b0, ~pt_d};
            default:          cmd_d = 3'b000;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q    <= S_IDLE;
            clr_q      <= 1'b0;
            pt_q       <= 1'b0;
            num_q      <= '0;
            cmd_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_err_q <= '0;
            jobs_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            pt_q       <= pt_d;
            num_q      <= num_d;
            cmd_q      <= cmd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_err_q <= last_err_d;
            jobs_q     <= jobs_d;
        end
    end

    assign cmd       = {29'd0, cmd_q};
    assign num_pkts  = num_q;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign done_irq  = done_q;
    assign err_irq   = err_q;
    assign last_err  = last_err_q;
    assign jobs_done = jobs_q;
endmodule
